// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter steering N valid/ready sources into one registered valid/ready sink.
// Priority rotates to the requester after the last one granted, so no source starves.
module rr_mux_arbiter #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int IW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [IW-1:0]  out_src,
  input  logic           out_ready
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] gnt;
  logic [IW-1:0] ptr_next;
  logic [IW:0]   cand;
  logic          found;
  logic          can_load;
  logic          load;
  logic [W-1:0]  sel_data;

  assign out_valid = (state == FULL);
  assign can_load  = !out_valid || out_ready;

  // Candidate index is reduced modulo N by hand so non-power-of-2 N never yields an index >= N.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!found && in_valid[cand[IW-1:0]]) begin
        gnt   = cand[IW-1:0];
        found = 1'b1;
      end
    end
  end

  assign load = found && can_load && !rst;

  always_comb begin
    in_ready = '0;
    if (load) in_ready[gnt] = 1'b1;
  end

  assign ptr_next = (gnt == IW'(N-1)) ? '0 : gnt + 1'b1;
  assign sel_data = in_data[int'(gnt)*W +: W];

  // Output register stage: a load may coincide with a drain, keeping one word per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      out_data <= '0;
      out_src  <= '0;
      ptr      <= '0;
    end else if (load) begin
      state    <= FULL;
      out_data <= sel_data;
      out_src  <= gnt;
      ptr      <= ptr_next;
    end else if (state == FULL && out_ready) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: a reference model predicts grants and pushes accepted
// words into a scoreboard that is popped whenever the sink handshakes.
module tb_rr_mux_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [IW-1:0]  out_src;
  logic           out_ready;

  int tests = 0;
  int fails = 0;
  int flushed = 0;
  int delivered = 0;

  logic [IW+W-1:0] sb[$];
  logic            mvalid = 1'b0;
  int              mptr = 0;

  // Previous-cycle inputs, used to check the requester hold contract.
  logic [N-1:0]    pv = '0;
  logic [N-1:0]    pr = '0;
  logic [N*W-1:0]  pd = '0;
  logic            prst = 1'b1;

  rr_mux_arbiter #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: settle inputs, predict and check in_ready, update model, then check state after the edge.
  task automatic cycle(string tag);
    int              g;
    int              idx;
    logic            found;
    logic            can;
    logic [N-1:0]    er;
    logic [IW+W-1:0] e;
    #1;
    if (!prst && !rst) begin
      for (int i = 0; i < N; i++) begin
        if (pv[i] && !pr[i])
          chk($sformatf("%s.hold%0d", tag, i), {23'd0, in_valid[i], in_data[i*W +: W]},
              {23'd0, 1'b1, pd[i*W +: W]});
      end
    end
    can   = !mvalid || out_ready;
    found = 1'b0;
    g     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (mptr + k) % N;
      if (!found && in_valid[idx]) begin
        g     = idx;
        found = 1'b1;
      end
    end
    er = '0;
    if (found && can && !rst) er[g] = 1'b1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(er));
    pv   = in_valid;
    pr   = in_ready;
    pd   = in_data;
    prst = rst;
    if (rst) begin
      if (mvalid) flushed++;
      sb.delete();
      mvalid = 1'b0;
      mptr   = 0;
    end else begin
      if (mvalid && out_ready) begin
        chk({tag, ".sb_depth"}, 32'(sb.size()), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk({tag, ".pop_src"}, 32'(out_src), 32'(e[IW+W-1:W]));
          chk({tag, ".pop_data"}, 32'(out_data), 32'(e[W-1:0]));
          delivered++;
        end
        mvalid = 1'b0;
      end
      if (er != '0) begin
        sb.push_back({IW'(g), in_data[g*W +: W]});
        mvalid = 1'b1;
        mptr   = (g + 1) % N;
      end
    end
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(mvalid));
    chk({tag, ".ptr"}, 32'(dut.ptr), 32'(mptr));
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b1;
    @(negedge clk);

    // Reset with all requesters asserting, then release idle.
    in_valid = 4'b1111;
    in_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int c = 0; c < 2; c++) begin
      cycle("rst_hold");
      chk("rst_hold.out_data", 32'(out_data), 32'h0);
      chk("rst_hold.out_src", 32'(out_src), 32'h0);
    end
    rst      = 1'b0;
    in_valid = '0;
    cycle("idle");
    chk("idle.out_valid", 32'(out_valid), 32'h0);
    chk("idle.out_data", 32'(out_data), 32'h0);

    // Single requester, one-cycle latency.
    in_valid = 4'b0100;
    in_data[2*W +: W] = 8'hA5;
    cycle("single");
    chk("single.out_valid", 32'(out_valid), 32'h1);
    chk("single.out_data", 32'(out_data), 32'hA5);
    chk("single.out_src", 32'(out_src), 32'h2);
    chk("single.ptr", 32'(dut.ptr), 32'h3);

    // Skip and wrap from ptr=3.
    in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    in_valid = 4'b0010;
    cycle("skip");
    chk("skip.out_src", 32'(out_src), 32'h1);
    chk("skip.ptr", 32'(dut.ptr), 32'h2);
    in_valid = 4'b1001;
    cycle("wrap");
    chk("wrap.out_src", 32'(out_src), 32'h3);
    chk("wrap.ptr", 32'(dut.ptr), 32'h0);

    // Full rotation, back to back.
    in_valid = 4'b1111;
    for (int j = 0; j < 6; j++) begin
      cycle("rot");
      chk("rot.out_src", 32'(out_src), 32'(j % 4));
      chk("rot.out_data", 32'(out_data), 32'(8'h10 + j % 4));
    end

    // Backpressure freezes the register and the pointer.
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      cycle("bp");
      chk("bp.out_src", 32'(out_src), 32'h1);
      chk("bp.out_data", 32'(out_data), 32'h11);
      chk("bp.ptr", 32'(dut.ptr), 32'h2);
    end
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      cycle("resume");
      chk("resume.out_src", 32'(out_src), 32'((j + 2) % 4));
    end

    // Reset while a word is held under backpressure: the word is flushed.
    out_ready = 1'b0;
    rst       = 1'b1;
    cycle("rst_mid");
    chk("rst_mid.out_valid", 32'(out_valid), 32'h0);
    chk("rst_mid.out_data", 32'(out_data), 32'h0);
    chk("rst_mid.flushed", 32'(flushed), 32'd1);
    rst       = 1'b0;
    in_valid  = '0;
    out_ready = 1'b1;
    cycle("post_rst");
    chk("post_rst.out_valid", 32'(out_valid), 32'h0);
    chk("post_rst.sb_left", 32'(sb.size()), 32'd0);
    chk("post_rst.delivered", 32'(delivered), 32'd11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
